// File: rtl/osd_regaccess_out_mux.sv
// ----------------------------------------------------------------------------
// osd_regaccess_out_mux
//
// Merges the register-access response stream (in_reg) and the module's own
// traffic (in_bypass) onto a single outgoing DI link.
//
// - Arbitration happens only on packet boundaries. Once the first flit of a
//   multi-flit packet has been accepted, the mux locks onto that source until
//   the flit carrying last=1 has been accepted.
// - The output is a single registered stage. It sustains one flit per cycle,
//   and the next packet's first flit can follow the previous last flit
//   without a bubble.
// - Flit layout (dii_flit, packed): [17] valid, [16] last, [15:0] data.
//
// Build option:
//   OSD_REGACCESS_OUT_MUX_PRIO_EN - when defined, an idle mux always prefers
//   in_reg over in_bypass (fixed priority). When undefined, simultaneous
//   requests from an idle mux are served round-robin.
// ----------------------------------------------------------------------------
module osd_regaccess_out_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] in_reg,
  output logic        in_reg_ready,
  input  logic [17:0] in_bypass,
  output logic        in_bypass_ready,
  output logic [17:0] out,
  input  logic        out_ready
);

  // Arbiter states: idle (free to pick), or locked onto one source mid-packet.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_REG = 2'd1,
    LOCK_BYP = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Unpacked views of the two input flits.
  logic        reg_valid_s;
  logic        reg_last_s;
  logic [15:0] reg_data_s;
  logic        byp_valid_s;
  logic        byp_last_s;
  logic [15:0] byp_data_s;

  // Output register.
  logic        out_valid_r;
  logic        out_last_r;
  logic [15:0] out_data_r;

  // Arbitration and handshake terms.
  logic        out_free_s;
  logic        idle_pick_reg_s;
  logic        idle_pick_byp_s;
  logic        grant_reg_s;
  logic        grant_byp_s;
  logic        accept_reg_s;
  logic        accept_byp_s;
  logic        accept_any_s;
  logic        sel_last_s;
  logic [15:0] sel_data_s;

`ifndef OSD_REGACCESS_OUT_MUX_PRIO_EN
  // Source encoding for the round-robin history bit.
  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_BYP = 1'b1;

  logic rr_last_r;
  logic rr_last_next_s;
`endif

  assign reg_valid_s = in_reg[17];
  assign reg_last_s  = in_reg[16];
  assign reg_data_s  = in_reg[15:0];
  assign byp_valid_s = in_bypass[17];
  assign byp_last_s  = in_bypass[16];
  assign byp_data_s  = in_bypass[15:0];

  // The output slot can take a new flit when it is empty or being drained.
  assign out_free_s = ~out_valid_r | out_ready;

  // Idle-state choice between the two sources; purely combinational so the
  // next packet starts in the cycle right after the previous last flit.
  always_comb begin
    idle_pick_reg_s = 1'b0;
    idle_pick_byp_s = 1'b0;
`ifdef OSD_REGACCESS_OUT_MUX_PRIO_EN
    // Fixed priority: register responses always win; bypass may wait.
    if (reg_valid_s) begin
      idle_pick_reg_s = 1'b1;
    end else if (byp_valid_s) begin
      idle_pick_byp_s = 1'b1;
    end else begin
      idle_pick_reg_s = 1'b0;
      idle_pick_byp_s = 1'b0;
    end
`else
    // Round-robin: on a tie, serve whichever source did not go last.
    if (reg_valid_s && byp_valid_s) begin
      if (rr_last_r == SRC_BYP) begin
        idle_pick_reg_s = 1'b1;
      end else begin
        idle_pick_byp_s = 1'b1;
      end
    end else if (reg_valid_s) begin
      idle_pick_reg_s = 1'b1;
    end else if (byp_valid_s) begin
      idle_pick_byp_s = 1'b1;
    end else begin
      idle_pick_reg_s = 1'b0;
      idle_pick_byp_s = 1'b0;
    end
`endif
  end

  // Grant per state: idle uses the arbiter pick, a locked state serves only
  // its own source (even while that source is momentarily not valid).
  always_comb begin
    grant_reg_s = 1'b0;
    grant_byp_s = 1'b0;
    case (state_r)
      IDLE: begin
        grant_reg_s = idle_pick_reg_s;
        grant_byp_s = idle_pick_byp_s;
      end
      LOCK_REG: begin
        grant_reg_s = 1'b1;
        grant_byp_s = 1'b0;
      end
      LOCK_BYP: begin
        grant_reg_s = 1'b0;
        grant_byp_s = 1'b1;
      end
      default: begin
        grant_reg_s = 1'b0;
        grant_byp_s = 1'b0;
      end
    endcase
  end

  // Readies are forced low while reset is asserted so nothing is taken from
  // upstream before the mux has come out of reset.
  assign in_reg_ready    = grant_reg_s & out_free_s & ~rst;
  assign in_bypass_ready = grant_byp_s & out_free_s & ~rst;

  assign accept_reg_s = reg_valid_s & in_reg_ready;
  assign accept_byp_s = byp_valid_s & in_bypass_ready;
  assign accept_any_s = accept_reg_s | accept_byp_s;

  // Data path select: at most one source is accepted in any cycle.
  always_comb begin
    sel_last_s = 1'b0;
    sel_data_s = 16'h0000;
    if (accept_reg_s) begin
      sel_last_s = reg_last_s;
      sel_data_s = reg_data_s;
    end else if (accept_byp_s) begin
      sel_last_s = byp_last_s;
      sel_data_s = byp_data_s;
    end else begin
      sel_last_s = 1'b0;
      sel_data_s = 16'h0000;
    end
  end

  // Next-state logic: lock on a non-last first flit, unlock on a last flit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_reg_s && !reg_last_s) begin
          state_next_s = LOCK_REG;
        end else if (accept_byp_s && !byp_last_s) begin
          state_next_s = LOCK_BYP;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCK_REG: begin
        if (accept_reg_s && reg_last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOCK_REG;
        end
      end
      LOCK_BYP: begin
        if (accept_byp_s && byp_last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOCK_BYP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

`ifndef OSD_REGACCESS_OUT_MUX_PRIO_EN
  // Round-robin history: remember which source started the latest packet.
  always_comb begin
    rr_last_next_s = rr_last_r;
    if (state_r == IDLE && accept_reg_s) begin
      rr_last_next_s = SRC_REG;
    end else if (state_r == IDLE && accept_byp_s) begin
      rr_last_next_s = SRC_BYP;
    end else begin
      rr_last_next_s = rr_last_r;
    end
  end

  // Round-robin history register; resets to bypass so in_reg wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= SRC_BYP;
    end else begin
      rr_last_r <= rr_last_next_s;
    end
  end
`endif

  // Output stage: load on accept, drop valid once drained, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= 16'h0000;
    end else if (accept_any_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= sel_last_s;
      out_data_r  <= sel_data_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out = {out_valid_r, out_last_r, out_data_r};

endmodule

// File: tb/tb_osd_regaccess_out_mux.sv
// ----------------------------------------------------------------------------
// tb_osd_regaccess_out_mux
//
// Self-checking bench for osd_regaccess_out_mux: a table of directed cycles,
// hand-written sequences for reset, stall and arbitration corner cases, and a
// randomized run against a packet-level reference model.
// Honours OSD_REGACCESS_OUT_MUX_PRIO_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_osd_regaccess_out_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] in_reg = 18'h0;
  logic [17:0] in_bypass = 18'h0;
  logic        out_ready = 1'b0;
  logic        in_reg_ready;
  logic        in_bypass_ready;
  logic [17:0] out;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] NONE = 18'h0;

  typedef struct {
    logic [17:0] reg_f;
    logic [17:0] byp_f;
    logic        ordy;
    logic        exp_rrdy;
    logic        exp_brdy;
    logic [17:0] exp_out;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  osd_regaccess_out_mux dut (
    .clk             (clk),
    .rst             (rst),
    .in_reg          (in_reg),
    .in_reg_ready    (in_reg_ready),
    .in_bypass       (in_bypass),
    .in_bypass_ready (in_bypass_ready),
    .out             (out),
    .out_ready       (out_ready)
  );

  function automatic logic [17:0] fl(input logic v, input logic l, input logic [15:0] d);
    return {v, l, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One clock cycle, entered and left at posedge+1: drive, check readies,
  // then check the registered output after the edge.
  task automatic cyc(input string nm, input logic [17:0] r, input logic [17:0] b,
                     input logic ordy, input logic er, input logic eb,
                     input logic [17:0] eo);
    in_reg = r;
    in_bypass = b;
    out_ready = ordy;
    #1;
    chk({nm, " in_reg_ready"}, 32'(in_reg_ready), 32'(er));
    chk({nm, " in_bypass_ready"}, 32'(in_bypass_ready), 32'(eb));
    @(posedge clk);
    #1;
    chk({nm, " out.valid"}, 32'(out[17]), 32'(eo[17]));
    if (eo[17]) chk({nm, " out.last/data"}, 32'(out[16:0]), 32'(eo[16:0]));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  // and stay cleared for three edges. Returns at posedge+1 after release.
  task automatic reset_mid(input string nm);
    #2;
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk({nm, " rst out"}, 32'(out), 32'(NONE));
    chk({nm, " rst readies"}, 32'({in_reg_ready, in_bypass_ready}), 32'(2'b00));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " rst hold out"}, 32'(out), 32'(NONE));
      chk({nm, " rst hold readies"}, 32'({in_reg_ready, in_bypass_ready}), 32'(2'b00));
    end
    @(negedge clk);
    in_reg = NONE;
    in_bypass = NONE;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Randomized run: drivers hold a flit until it is taken; the model predicts
  // grants from the packet-boundary rules and tracks the single output slot.
  task automatic random_run(input int ncyc);
    logic [17:0] qr[$];
    logic [17:0] qb[$];
    bit   pres_r = 1'b0, pres_b = 1'b0;
    int   pk_r = 0, pk_b = 0;
    int   lock = -1;      // -1 none, 0 reg, 1 bypass
    int   last_src = 1;   // source that started the latest packet
    int   g;
    bit   free, er, eb, acc_r, acc_b, rv, bv, ordy;
    logic [17:0] f;
    logic        m_v = 1'b0;
    logic [16:0] m_f = 17'h0;
    for (int c = 0; c < ncyc; c++) begin
      if (qr.size() == 0 && $urandom_range(0, 2) == 0) begin
        int len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++)
          qr.push_back(fl(1'b1, i == len - 1, {4'hA, 8'(pk_r), 4'(i)}));
        pk_r++;
      end
      if (qb.size() == 0 && $urandom_range(0, 2) == 0) begin
        int len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++)
          qb.push_back(fl(1'b1, i == len - 1, {4'hB, 8'(pk_b), 4'(i)}));
        pk_b++;
      end
      if (!pres_r && qr.size() > 0 && $urandom_range(0, 3) != 0) pres_r = 1'b1;
      if (!pres_b && qb.size() > 0 && $urandom_range(0, 3) != 0) pres_b = 1'b1;
      rv = pres_r;
      bv = pres_b;
      ordy = ($urandom_range(0, 3) != 0);
      in_reg = rv ? qr[0] : {1'b0, 17'($urandom)};
      in_bypass = bv ? qb[0] : {1'b0, 17'($urandom)};
      out_ready = ordy;
      #1;
      free = !m_v || ordy;
      if (lock >= 0) g = lock;
`ifdef OSD_REGACCESS_OUT_MUX_PRIO_EN
      else if (rv) g = 0;
`else
      else if (rv && bv) g = (last_src == 0) ? 1 : 0;
      else if (rv) g = 0;
`endif
      else if (bv) g = 1;
      else g = -1;
      er = (g == 0) && free;
      eb = (g == 1) && free;
      chk("rand in_reg_ready", 32'(in_reg_ready), 32'(er));
      chk("rand in_bypass_ready", 32'(in_bypass_ready), 32'(eb));
      acc_r = rv && er;
      acc_b = bv && eb;
      if (acc_r || acc_b) begin
        f = acc_r ? qr.pop_front() : qb.pop_front();
        if (acc_r) pres_r = 1'b0;
        else pres_b = 1'b0;
        m_v = 1'b1;
        m_f = f[16:0];
        if (lock < 0) last_src = acc_r ? 0 : 1;
        lock = f[16] ? -1 : (acc_r ? 0 : 1);
      end else if (ordy) begin
        m_v = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rand out.valid", 32'(out[17]), 32'(m_v));
      if (m_v) chk("rand out.last/data", 32'(out[16:0]), 32'(m_f));
    end
  endtask

  initial begin
    // Directed table: two 4-flit packets arriving together, then a reg packet.
    vecs[0]  = '{fl(1, 0, 16'hA000), fl(1, 0, 16'hB000), 1'b1, 1'b1, 1'b0, fl(1, 0, 16'hA000)};
    vecs[1]  = '{fl(1, 0, 16'hA001), fl(1, 0, 16'hB000), 1'b1, 1'b1, 1'b0, fl(1, 0, 16'hA001)};
    vecs[2]  = '{fl(1, 0, 16'hA002), fl(1, 0, 16'hB000), 1'b1, 1'b1, 1'b0, fl(1, 0, 16'hA002)};
    vecs[3]  = '{fl(1, 1, 16'hA003), fl(1, 0, 16'hB000), 1'b1, 1'b1, 1'b0, fl(1, 1, 16'hA003)};
    vecs[4]  = '{NONE,               fl(1, 0, 16'hB000), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'hB000)};
    vecs[5]  = '{NONE,               fl(1, 0, 16'hB001), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'hB001)};
    vecs[6]  = '{NONE,               fl(1, 0, 16'hB002), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'hB002)};
    vecs[7]  = '{NONE,               fl(1, 1, 16'hB003), 1'b1, 1'b0, 1'b1, fl(1, 1, 16'hB003)};
    vecs[8]  = '{NONE,               NONE,               1'b1, 1'b0, 1'b0, NONE};
    vecs[9]  = '{fl(1, 0, 16'h0001), NONE,               1'b1, 1'b1, 1'b0, fl(1, 0, 16'h0001)};
    vecs[10] = '{fl(1, 0, 16'h0002), NONE,               1'b1, 1'b1, 1'b0, fl(1, 0, 16'h0002)};
    vecs[11] = '{fl(1, 1, 16'h0003), NONE,               1'b1, 1'b1, 1'b0, fl(1, 1, 16'h0003)};
    vecs[12] = '{NONE,               NONE,               1'b1, 1'b0, 1'b0, NONE};

    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    chk("por out", 32'(out), 32'(NONE));
    chk("por readies", 32'({in_reg_ready, in_bypass_ready}), 32'(2'b00));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Async reset while out.valid=1 (held by out_ready=0).
    cyc("t1 load", fl(1, 1, 16'h5A5A), NONE, 1'b0, 1'b1, 1'b0, fl(1, 1, 16'h5A5A));
    reset_mid("t1");

    // Table vectors.
    for (int i = 0; i < 13; i++)
      cyc($sformatf("vec%0d", i), vecs[i].reg_f, vecs[i].byp_f, vecs[i].ordy,
          vecs[i].exp_rrdy, vecs[i].exp_brdy, vecs[i].exp_out);
    reset_mid("t3");

    // Bypass packet stalled after its 2nd flit while in_reg waits.
    cyc("t4 b0", NONE, fl(1, 0, 16'hB000), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'hB000));
    cyc("t4 b1", fl(1, 1, 16'hC000), fl(1, 0, 16'hB001), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'hB001));
    for (int i = 0; i < 5; i++)
      cyc("t4 stall", fl(1, 1, 16'hC000), fl(1, 0, 16'hB002), 1'b0, 1'b0, 1'b0, fl(1, 0, 16'hB001));
    cyc("t4 b2", fl(1, 1, 16'hC000), fl(1, 0, 16'hB002), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'hB002));
    cyc("t4 b3", fl(1, 1, 16'hC000), fl(1, 1, 16'hB003), 1'b1, 1'b0, 1'b1, fl(1, 1, 16'hB003));
    cyc("t4 reg", fl(1, 1, 16'hC000), NONE, 1'b1, 1'b1, 1'b0, fl(1, 1, 16'hC000));
    cyc("t4 idle", NONE, NONE, 1'b1, 1'b0, 1'b0, NONE);
    reset_mid("t4");

    // Continuous single-flit packets on both inputs.
    begin
      int rc = 0, bc = 0;
      for (int k = 0; k < 10; k++) begin
        logic pick_reg;
`ifdef OSD_REGACCESS_OUT_MUX_PRIO_EN
        pick_reg = 1'b1;
`else
        pick_reg = (k % 2 == 0);
`endif
        cyc($sformatf("t5 k%0d", k), fl(1, 1, 16'hD000 + 16'(rc)), fl(1, 1, 16'hE000 + 16'(bc)),
            1'b1, pick_reg, !pick_reg,
            pick_reg ? fl(1, 1, 16'hD000 + 16'(rc)) : fl(1, 1, 16'hE000 + 16'(bc)));
        if (pick_reg) rc++;
        else bc++;
      end
      cyc("t5 byp", NONE, fl(1, 1, 16'hE000 + 16'(bc)), 1'b1, 1'b0, 1'b1, fl(1, 1, 16'hE000 + 16'(bc)));
    end
    reset_mid("t5");

    // Reset during the 2nd flit of a reg packet, then a bypass packet.
    cyc("t6 r0", fl(1, 0, 16'hF000), NONE, 1'b1, 1'b1, 1'b0, fl(1, 0, 16'hF000));
    in_reg = fl(1, 0, 16'hF001);
    reset_mid("t6");
    cyc("t6 b0", NONE, fl(1, 0, 16'h9000), 1'b1, 1'b0, 1'b1, fl(1, 0, 16'h9000));
    cyc("t6 b1", NONE, fl(1, 1, 16'h9001), 1'b1, 1'b0, 1'b1, fl(1, 1, 16'h9001));
    cyc("t6 idle", NONE, NONE, 1'b1, 1'b0, 1'b0, NONE);
    reset_mid("t6b");

    random_run(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
